// File: rtl/fc_layer_sequencer.sv
// Row-by-row MAC control for an MxN fully-connected layer; optional WB stall counter under FC_SEQ_STALL_CNT_EN.
// Latency: N+3 cycles per row, M*(N+3)+1 cycles from the first BIAS cycle through DONE.
// Backpressure: WB holds wb_valid/wb_idx with every strobe low until wb_ready; start is ignored while busy.
module fc_layer_sequencer #(
  parameter int M = 4,
  parameter int N = 4,
  localparam int WAW = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int XAW = (N > 1) ? $clog2(N) : 1,
  localparam int BAW = (M > 1) ? $clog2(M) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [BAW-1:0] b_addr,
  output logic [WAW-1:0] w_addr,
  output logic [XAW-1:0] x_addr,
  output logic           acc_load,
  output logic           acc_en,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic [BAW-1:0] wb_idx
`ifdef FC_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WB    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [BAW-1:0] row_q, row_d;
  logic [XAW-1:0] col_q, col_d;
  logic [WAW-1:0] w_addr_q, w_addr_d;

  assign b_addr = row_q;
  assign w_addr = w_addr_q;
  assign x_addr = col_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    w_addr_d = w_addr_q;
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    acc_load = 1'b0;
    acc_en   = 1'b0;
    wb_valid = 1'b0;
    wb_idx   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_BIAS;
          row_d    = '0;
          col_d    = '0;
          w_addr_d = '0;
        end
      end
      S_BIAS: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        state_d = S_MAC;
      end
      S_MAC: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        // The bias read lands this cycle; each later MAC cycle consumes the previous weight read.
        acc_load = (col_q == '0);
        acc_en   = (col_q != '0);
        w_addr_d = (w_addr_q == WAW'(M * N - 1)) ? '0 : w_addr_q + 1'b1;
        if (col_q == XAW'(N - 1)) begin
          col_d   = '0;
          state_d = S_DRAIN;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        acc_en  = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        busy     = 1'b1;
        wb_valid = 1'b1;
        wb_idx   = row_q;
        if (wb_ready) begin
          if (row_q == BAW'(M - 1)) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_BIAS;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      w_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      w_addr_q <= w_addr_d;
    end
  end

`ifdef FC_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start) begin
      stall_cnt_d = '0;
    end else if (state_q == S_WB && !wb_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer: M=4,N=4 instance plus an M=1,N=1 instance.
module tb_fc_layer_sequencer;
  localparam int M = 4;
  localparam int N = 4;
  localparam int WAW = $clog2(M * N);
  localparam int XAW = $clog2(N);
  localparam int BAW = $clog2(M);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic           wb_ready = 1'b0;
  logic           busy, done, rd_en, acc_load, acc_en, wb_valid;
  logic [BAW-1:0] b_addr, wb_idx;
  logic [WAW-1:0] w_addr;
  logic [XAW-1:0] x_addr;
`ifdef FC_SEQ_STALL_CNT_EN
  logic [15:0]    stall_cnt, stall_cnt1;
`endif

  logic start1 = 1'b0;
  logic wb_ready1 = 1'b1;
  logic busy1, done1, rd_en1, acc_load1, acc_en1, wb_valid1;
  logic b_addr1, w_addr1, x_addr1, wb_idx1;

  fc_layer_sequencer #(.M(M), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .b_addr(b_addr), .w_addr(w_addr), .x_addr(x_addr), .acc_load(acc_load),
    .acc_en(acc_en), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_idx(wb_idx)
`ifdef FC_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  fc_layer_sequencer #(.M(1), .N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .rd_en(rd_en1),
    .b_addr(b_addr1), .w_addr(w_addr1), .x_addr(x_addr1), .acc_load(acc_load1),
    .acc_en(acc_en1), .wb_valid(wb_valid1), .wb_ready(wb_ready1), .wb_idx(wb_idx1)
`ifdef FC_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_cnt1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq(tag, {16'd0, busy, done, rd_en, acc_load, acc_en, wb_valid,
                   b_addr, w_addr, x_addr, wb_idx}, 32'd0);
  endtask

  // Runs one layer from IDLE; cycle 1 is the first BIAS cycle. Bias data=10, x=w=1.
  task automatic run_layer(input int stall_row, input int stall_len, input bit hold_start,
                           output int done_cyc, output int rd_cnt);
    int cyc, exp_row, exp_w, en_cnt, acc, stalled;
    bit first_wb, prev_rd, prev_wbv, prev_rdy;
    logic [BAW-1:0] prev_b;
    logic [WAW-1:0] prev_w;
    logic [XAW-1:0] prev_x;
    cyc = 1; exp_row = 0; exp_w = 0; en_cnt = 0; acc = 0; stalled = 0;
    first_wb = 1; prev_rd = 0; prev_wbv = 0; prev_rdy = 1;
    prev_b = '0; prev_w = '0; prev_x = '0;
    done_cyc = -1; rd_cnt = 0;
    start = 1'b1;
    wb_ready = 1'b1;
    tick();
    start = hold_start;
    check_eq("busy_after_start", busy, 1);
`ifdef FC_SEQ_STALL_CNT_EN
    check_eq("stall_cnt_cleared", stall_cnt, 0);
`endif
    while (cyc <= 300) begin
      if (acc_load) begin
        check_eq("load_after_bias_rd", prev_rd, 1);
        check_eq("load_b_addr", prev_b, exp_row);
        acc = prev_rd ? 10 : 0;
        en_cnt = 0;
      end
      if (acc_en) begin
        check_eq("en_after_w_rd", prev_rd, 1);
        check_eq("en_w_addr", prev_w, exp_w);
        check_eq("en_x_addr", prev_x, exp_w % N);
        exp_w++;
        en_cnt++;
        acc = acc + (prev_rd ? 1 : 0);
      end
      if (rd_en) rd_cnt++;
      if (prev_wbv && !prev_rdy) check_eq("wb_valid_held", wb_valid, 1);
      if (wb_valid) begin
        check_eq("wb_idx", wb_idx, exp_row);
        if (first_wb) begin
          check_eq("row_result", acc, 10 + N);
          check_eq("acc_en_per_row", en_cnt, N);
          first_wb = 0;
        end
        if (exp_row == stall_row && stalled < stall_len) begin
          check_eq("stall_strobes_quiet", {rd_en, acc_load, acc_en}, 0);
          wb_ready = 1'b0;
          stalled++;
        end else begin
          wb_ready = 1'b1;
          exp_row++;
          first_wb = 1;
        end
      end else begin
        wb_ready = 1'b1;
      end
      if (done) begin
        done_cyc = cyc;
        check_eq("done_busy", busy, 1);
        break;
      end
      prev_rd = rd_en; prev_b = b_addr; prev_w = w_addr; prev_x = x_addr;
      prev_wbv = wb_valid; prev_rdy = wb_ready;
      tick();
      cyc++;
    end
    if (done_cyc < 0) check_eq("done_timeout", 0, 1);
    check_eq("rows_written", exp_row, M);
    check_eq("w_reads", exp_w, M * N);
    tick();
    start = 1'b0;
    check_idle("idle_after_done");
    tick();
    check_eq("no_second_layer", busy, 0);
  endtask

  initial begin
    int dc, rc, cyc, n_done;
    #1000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

  initial begin
    int dc, rc, cyc, n_done;
    rst = 1'b0;
    tick();
    tick();
    check_idle("reset");
    check_eq("reset_dut1", {busy1, done1, rd_en1, acc_load1, acc_en1, wb_valid1,
                            b_addr1, w_addr1, x_addr1, wb_idx1}, 0);
    rst = 1'b1;
    tick();
    check_eq("idle_no_start", busy, 0);

    // Unstalled layer.
    run_layer(-1, 0, 0, dc, rc);
    check_eq("done_cycle", dc, 29);
    check_eq("rd_en_count", rc, 20);

    // Row 1 writeback stalled for 3 cycles.
    run_layer(1, 3, 0, dc, rc);
    check_eq("done_cycle_stall", dc, 32);
    check_eq("rd_en_count_stall", rc, 20);
`ifdef FC_SEQ_STALL_CNT_EN
    check_eq("stall_cnt_held", stall_cnt, 3);
`endif

    // start held high throughout, including DONE; w_addr restarts at 0.
    run_layer(-1, 0, 1, dc, rc);
    check_eq("done_cycle_hold", dc, 29);
`ifdef FC_SEQ_STALL_CNT_EN
    check_eq("stall_cnt_zero", stall_cnt, 0);
`endif

    // Reset during row 2 MAC (cycle 17) aborts without a done pulse.
    start = 1'b1;
    wb_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check_eq("mid_row2_mac", {acc_en, rd_en, b_addr}, {1'b1, 1'b1, 2'd2});
    rst = 1'b0;
    tick();
    check_idle("abort_reset");
    rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) n_done++;
      tick();
    end
    check_eq("abort_no_done", n_done, 0);
    check_eq("abort_stays_idle", busy, 0);

    // M=1, N=1 instance.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    dc = -1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (done1) begin
        dc = cyc;
        break;
      end
      tick();
    end
    check_eq("m1n1_done_cycle", dc, 5);
    tick();
    check_eq("m1n1_idle", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
